controlador_irrigacao: RTL

Parametrised multi-zone irrigation controller. It manages tank filling from three level sensors, then serves N irrigation zones by round-robin, one at a time. Each grant runs a per-request duration in sprinkler or drip mode. After each irrigation it runs a timed cleaning interval, and it enters a sticky error state with an error code that only an explicit rearm clears. It sits between the tank/zone sensor inputs and the valve/pump drive outputs.

---
 rtl/irrigacao_pkg.sv | 21 ++
 rtl/controlador_irrigacao_arbitro_rr.sv | 40 ++++
 rtl/controlador_irrigacao.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/irrigacao_pkg.sv
// Shared constants for the irrigation controller: FSM state encodings,
// error codes and the tank sensor consistency rule.
package irrigacao_pkg;

    localparam logic [2:0] ENCHENDO  = 3'd0;
    localparam logic [2:0] CHEIO     = 3'd1;
    localparam logic [2:0] IRRIGANDO = 3'd2;
    localparam logic [2:0] LIMPANDO  = 3'd4;
    localparam logic [2:0] ERRO      = 3'd5;

    localparam logic [1:0] ERR_NENHUM  = 2'd0;
    localparam logic [1:0] ERR_EXTERNO = 2'd1;
    localparam logic [1:0] ERR_SENSOR  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // A higher sensor may never be wet while a lower one is dry.
    function automatic logic sensor_inconsistente(input logic h, input logic m, input logic l);
        return (h & ~m) | (m & ~l) | (h & ~l);
    endfunction

endpackage

// File: rtl/controlador_irrigacao_arbitro_rr.sv
// Round-robin arbiter: grants the first requester strictly above ptr,
// wrapping to the lowest requester when none is above it.
module arbitro_rr #(
    parameter int N_ZONAS = 4,
    parameter int IDX_W   = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1
) (
    input  logic [N_ZONAS-1:0] pedido,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_ZONAS-1:0] concessao,
    output logic [IDX_W-1:0]   indice,
    output logic               valido
);

    logic [N_ZONAS-1:0] mascara;
    logic [N_ZONAS-1:0] acima;
    logic [N_ZONAS-1:0] alvo;

    generate
        for (genvar gi = 0; gi < N_ZONAS; gi++) begin : g_mascara
            assign mascara[gi] = (IDX_W'(gi) > ptr);
        end
    endgenerate

    assign acima  = pedido & mascara;
    assign alvo   = (|acima) ? acima : pedido;
    assign valido = |pedido;

    // Isolate the lowest set bit of the selected request vector.
    assign concessao = alvo & (~alvo + 1'b1);

    always_comb begin
        indice = '0;
        for (int i = N_ZONAS - 1; i >= 0; i--) begin
            if (alvo[i]) begin
                indice = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/controlador_irrigacao.sv
// Multi-zone irrigation controller: tank fill, round-robin zone service,
// cleaning interval and sticky error. Optional macro: IRRIGACAO_VERIFICA_SENSOR_EN.
module controlador_irrigacao
    import irrigacao_pkg::*;
#(
    parameter int N_ZONAS          = 4,
    parameter int TEMPO_W          = 8,
    parameter int T_LIMPEZA        = 16,
    parameter int T_ENCHIMENTO_MAX = 200
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               H,
    input  logic               M,
    input  logic               L,
    input  logic               E,
    input  logic               Rearme,
    input  logic [N_ZONAS-1:0] Pedido,
    input  logic [N_ZONAS-1:0] Modo,
    input  logic [TEMPO_W-1:0] Duracao,
    output logic               S_Enchendo,
    output logic               S_Cheio,
    output logic               S_Limpando,
    output logic               S_Erro,
    output logic               S_Aspersao,
    output logic               S_Gotejamento,
    output logic [N_ZONAS-1:0] S_Zona,
    output logic [1:0]         S_Codigo_Erro
);

    localparam int IDX_W  = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1;
    localparam int ENCH_W = $clog2(T_ENCHIMENTO_MAX + 1);
    localparam int LIMP_W = $clog2(T_LIMPEZA + 1);

    localparam logic [ENCH_W-1:0]  ENCH_LIM  = ENCH_W'(T_ENCHIMENTO_MAX - 1);
    localparam logic [LIMP_W-1:0]  LIMP_LIM  = LIMP_W'(T_LIMPEZA - 1);
    localparam logic [TEMPO_W-1:0] TIMER_UM  = TEMPO_W'(1);
    localparam logic [IDX_W-1:0]   PTR_RESET = IDX_W'(N_ZONAS - 1);

    logic [2:0]         estado_reg, estado_next;
    logic [1:0]         codigo_reg, codigo_next;
    logic [ENCH_W-1:0]  cnt_ench_reg, cnt_ench_next;
    logic [LIMP_W-1:0]  cnt_limp_reg, cnt_limp_next;
    logic [TEMPO_W-1:0] timer_reg, timer_next;
    logic [N_ZONAS-1:0] zona_reg, zona_next;
    logic               modo_reg, modo_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;

    logic [N_ZONAS-1:0] concessao;
    logic [IDX_W-1:0]   indice;
    logic               valido;
    logic               falha_sensor;
    logic               timeout;
    logic               pedido_ativo;
    logic               irrigando;

`ifdef IRRIGACAO_VERIFICA_SENSOR_EN
    assign falha_sensor = sensor_inconsistente(H, M, L);
`else
    // Medium sensor only feeds the consistency check.
    logic unused_m;
    assign unused_m     = M;
    assign falha_sensor = 1'b0;
`endif

    arbitro_rr #(
        .N_ZONAS (N_ZONAS),
        .IDX_W   (IDX_W)
    ) u_arbitro (
        .pedido    (Pedido),
        .ptr       (ptr_reg),
        .concessao (concessao),
        .indice    (indice),
        .valido    (valido)
    );

    assign timeout      = (estado_reg == ENCHENDO) && !H && (cnt_ench_reg == ENCH_LIM);
    assign pedido_ativo = |(Pedido & zona_reg);

    always_comb begin
        estado_next = estado_reg;
        codigo_next = codigo_reg;
        timer_next  = timer_reg;
        zona_next   = zona_reg;
        modo_next   = modo_reg;
        ptr_next    = ptr_reg;

        if (estado_reg == ERRO) begin
            if (Rearme && !E && !falha_sensor) begin
                estado_next = ENCHENDO;
                codigo_next = ERR_NENHUM;
            end
        end else if (E) begin
            estado_next = ERRO;
            codigo_next = ERR_EXTERNO;
        end else if (falha_sensor) begin
            estado_next = ERRO;
            codigo_next = ERR_SENSOR;
        end else if (timeout) begin
            estado_next = ERRO;
            codigo_next = ERR_TIMEOUT;
        end else begin
            case (estado_reg)
                ENCHENDO: begin
                    if (H) begin
                        estado_next = CHEIO;
                    end
                end
                CHEIO: begin
                    if (valido) begin
                        zona_next   = concessao;
                        modo_next   = Modo[indice];
                        timer_next  = (Duracao == '0) ? TIMER_UM : Duracao;
                        ptr_next    = indice;
                        estado_next = IRRIGANDO;
                    end
                end
                IRRIGANDO: begin
                    timer_next = timer_reg - 1'b1;
                    if (timer_reg == TIMER_UM) begin
                        estado_next = LIMPANDO;
                    end else if (!pedido_ativo) begin
                        estado_next = LIMPANDO;
                    end else if (!L) begin
                        estado_next = ENCHENDO;
                    end
                end
                LIMPANDO: begin
                    if (cnt_limp_reg == LIMP_LIM) begin
                        estado_next = H ? CHEIO : ENCHENDO;
                    end
                end
                default: begin
                    estado_next = ENCHENDO;
                end
            endcase
        end
    end

    // Counters only run while their state persists; any exit or entry restarts them.
    always_comb begin
        cnt_ench_next = '0;
        cnt_limp_next = '0;
        if ((estado_reg == ENCHENDO) && (estado_next == ENCHENDO)) begin
            cnt_ench_next = cnt_ench_reg + 1'b1;
        end
        if ((estado_reg == LIMPANDO) && (estado_next == LIMPANDO)) begin
            cnt_limp_next = cnt_limp_reg + 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado_reg   <= ENCHENDO;
            codigo_reg   <= ERR_NENHUM;
            cnt_ench_reg <= '0;
            cnt_limp_reg <= '0;
            timer_reg    <= '0;
            zona_reg     <= '0;
            modo_reg     <= 1'b0;
            ptr_reg      <= PTR_RESET;
        end else begin
            estado_reg   <= estado_next;
            codigo_reg   <= codigo_next;
            cnt_ench_reg <= cnt_ench_next;
            cnt_limp_reg <= cnt_limp_next;
            timer_reg    <= timer_next;
            zona_reg     <= zona_next;
            modo_reg     <= modo_next;
            ptr_reg      <= ptr_next;
        end
    end

    assign irrigando     = (estado_reg == IRRIGANDO);
    assign S_Enchendo    = (estado_reg == ENCHENDO);
    assign S_Cheio       = (estado_reg == CHEIO);
    assign S_Limpando    = (estado_reg == LIMPANDO);
    assign S_Erro        = (estado_reg == ERRO);
    assign S_Aspersao    = irrigando & modo_reg;
    assign S_Gotejamento = irrigando & ~modo_reg;
    assign S_Codigo_Erro = codigo_reg;

    generate
        for (genvar gi = 0; gi < N_ZONAS; gi++) begin : g_zona
            assign S_Zona[gi] = irrigando & zona_reg[gi];
        end
    endgenerate

endmodule
